// File: rtl/uart_stress_source.sv
// rtl/uart_stress_source.sv - counting-byte loopback source with windowed echo checker
// Optional echo timeout enabled by defining UART_STRESS_TIMEOUT_EN.
module uart_stress_source #(
    parameter int         WINDOW         = 4,
    parameter int         TIMEOUT_CYCLES = 1000000,
    parameter logic [7:0] SEED           = 8'h00
) (
    input  logic       SYSCLK,
    input  logic       SYSRST,
    input  logic       START,
    input  logic       ABORT,
    input  logic [7:0] BURST_LEN,
    input  logic       TX_READY,
    output logic       TX_VALID,
    output logic [7:0] TX_DATA,
    input  logic       RX_VALID,
    input  logic [7:0] RX_DATA,
    output logic       BUSY,
    output logic       DONE,
    output logic       PASS,
    output logic [7:0] SENT,
    output logic [7:0] GOOD,
    output logic [7:0] BAD,
    output logic [7:0] TIMEOUTS
);
    typedef enum logic [1:0] {S_IDLE, S_SEND, S_DRAIN} state_t;

    localparam logic [3:0] WIN = 4'(WINDOW);

    if (WINDOW < 1 || WINDOW > 15 || TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 16777216) begin : g_param_check
        $error("uart_stress_source: parameter out of range");
    end

    state_t     state_q, state_d;
    logic [7:0] len_q, len_d;
    logic [7:0] sent_q, sent_d;
    logic [7:0] good_q, good_d;
    logic [7:0] bad_q, bad_d;
    logic [7:0] timeouts_q, timeouts_d;
    logic       pass_q, pass_d;
    logic       done_q, done_d;
    logic       busy_q, busy_d;
    logic       txv_q, txv_d;
    logic       txv_hist_q;
    logic [7:0] tx_data_q, tx_data_d;
    logic [7:0] tx_seq_q, tx_seq_d;
    logic [7:0] rx_seq_q, rx_seq_d;
    logic [3:0] outst_q, outst_d;
    logic       send_fire;
    logic       rx_take;
`ifdef UART_STRESS_TIMEOUT_EN
    localparam logic [23:0] TO_LAST = 24'(TIMEOUT_CYCLES - 1);
    logic [23:0] idle_q, idle_d;
`endif

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    always_comb begin
        state_d    = state_q;
        len_d      = len_q;
        sent_d     = sent_q;
        good_d     = good_q;
        bad_d      = bad_q;
        timeouts_d = timeouts_q;
        pass_d     = pass_q;
        done_d     = 1'b0;
        busy_d     = busy_q;
        txv_d      = 1'b0;
        tx_data_d  = tx_data_q;
        tx_seq_d   = tx_seq_q;
        rx_seq_d   = rx_seq_q;
        outst_d    = outst_q;
        send_fire  = 1'b0;
        rx_take    = 1'b0;
`ifdef UART_STRESS_TIMEOUT_EN
        idle_d     = idle_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (START && BURST_LEN != 8'd0) begin
                    state_d  = S_SEND;
                    busy_d   = 1'b1;
                    len_d    = BURST_LEN;
                    sent_d   = 8'd0;
                    good_d   = 8'd0;
                    bad_d    = 8'd0;
                    pass_d   = 1'b0;
                    outst_d  = 4'd0;
                    tx_seq_d = SEED;
                    rx_seq_d = SEED;
`ifdef UART_STRESS_TIMEOUT_EN
                    idle_d   = 24'd0;
`endif
                end
            end
            S_SEND, S_DRAIN: begin
                if (ABORT) begin
                    state_d = S_IDLE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    pass_d  = 1'b0;
                end else begin
                    // two-cycle TX_VALID history lets the UART drop TX_READY after accepting
                    send_fire = (state_q == S_SEND) && TX_READY && (outst_q < WIN) && !txv_q && !txv_hist_q;
                    rx_take   = RX_VALID && (outst_q != 4'd0);
                    if (send_fire) begin
                        txv_d     = 1'b1;
                        tx_data_d = tx_seq_q;
                        tx_seq_d  = tx_seq_q + 8'd1;
                        sent_d    = sent_q + 8'd1;
                    end
                    if (RX_VALID) begin
                        if (rx_take && RX_DATA == rx_seq_q) good_d = sat_inc(good_q);
                        else                                bad_d  = sat_inc(bad_q);
                        if (rx_take) rx_seq_d = rx_seq_q + 8'd1;
                    end
                    outst_d = outst_q + {3'b000, send_fire} - {3'b000, rx_take};
                    if (state_q == S_SEND && sent_d == len_q) state_d = S_DRAIN;
                    if (state_q == S_DRAIN && outst_q == 4'd0) begin
                        state_d = S_IDLE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        pass_d  = (good_d == len_q) && (bad_d == 8'd0);
                    end
`ifdef UART_STRESS_TIMEOUT_EN
                    if (send_fire || RX_VALID) begin
                        idle_d = 24'd0;
                    end else if (outst_q != 4'd0) begin
                        idle_d = idle_q + 24'd1;
                        if (idle_d == TO_LAST) begin
                            timeouts_d = sat_inc(timeouts_q);
                            state_d    = S_IDLE;
                            busy_d     = 1'b0;
                            done_d     = 1'b1;
                            pass_d     = 1'b0;
                        end
                    end
`endif
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge SYSCLK) begin
        if (!SYSRST) begin
            state_q    <= S_IDLE;
            len_q      <= 8'd0;
            sent_q     <= 8'd0;
            good_q     <= 8'd0;
            bad_q      <= 8'd0;
            timeouts_q <= 8'd0;
            pass_q     <= 1'b0;
            done_q     <= 1'b0;
            busy_q     <= 1'b0;
            txv_q      <= 1'b0;
            txv_hist_q <= 1'b0;
            tx_data_q  <= 8'd0;
            tx_seq_q   <= 8'd0;
            rx_seq_q   <= 8'd0;
            outst_q    <= 4'd0;
`ifdef UART_STRESS_TIMEOUT_EN
            idle_q     <= 24'd0;
`endif
        end else begin
            state_q    <= state_d;
            len_q      <= len_d;
            sent_q     <= sent_d;
            good_q     <= good_d;
            bad_q      <= bad_d;
            timeouts_q <= timeouts_d;
            pass_q     <= pass_d;
            done_q     <= done_d;
            busy_q     <= busy_d;
            txv_q      <= txv_d;
            txv_hist_q <= txv_q;
            tx_data_q  <= tx_data_d;
            tx_seq_q   <= tx_seq_d;
            rx_seq_q   <= rx_seq_d;
            outst_q    <= outst_d;
`ifdef UART_STRESS_TIMEOUT_EN
            idle_q     <= idle_d;
`endif
        end
    end

    assign TX_VALID = txv_q;
    assign TX_DATA  = tx_data_q;
    assign BUSY     = busy_q;
    assign DONE     = done_q;
    assign PASS     = pass_q;
    assign SENT     = sent_q;
    assign GOOD     = good_q;
    assign BAD      = bad_q;
    assign TIMEOUTS = timeouts_q;
endmodule

// File: tb/tb_uart_stress_source.sv
// tb/tb_uart_stress_source.sv - self-checking bench for uart_stress_source with an echoing UART model
// Timeout sequence compiled only when UART_STRESS_TIMEOUT_EN is defined.
module tb_uart_stress_source;
    localparam int         WIN  = 4;
    localparam logic [7:0] SEED = 8'h00;

    logic       clk = 1'b0;
    logic       sysrst, start, abort_i, tx_ready, rx_valid;
    logic [7:0] burst_len, rx_data;
    logic       tx_valid, busy, done, pass;
    logic [7:0] tx_data, sent, good, bad, timeouts;

    always #5 clk = ~clk;

    uart_stress_source #(.WINDOW(WIN), .TIMEOUT_CYCLES(64), .SEED(SEED)) dut (
        .SYSCLK(clk), .SYSRST(sysrst), .START(start), .ABORT(abort_i), .BURST_LEN(burst_len),
        .TX_READY(tx_ready), .TX_VALID(tx_valid), .TX_DATA(tx_data),
        .RX_VALID(rx_valid), .RX_DATA(rx_data), .BUSY(busy), .DONE(done), .PASS(pass),
        .SENT(sent), .GOOD(good), .BAD(bad), .TIMEOUTS(timeouts)
    );

    typedef struct { int t; logic [7:0] d; } echo_t;
    typedef struct { logic [7:0] len; int corrupt; logic [7:0] e_good; logic [7:0] e_bad; logic e_pass; } vec_t;

    echo_t      echo_q[$];
    logic [7:0] tx_log[$];
    vec_t       vecs[5];
    int cyc = 0, n_checks = 0, n_pass = 0;
    int done_cnt, done_cyc, last_rx_cyc, last_tx_cyc, last_echo_t, inflight, n_corrupt;
    int corrupt_idx = -1, drop_idx = -1;
    bit echo_en = 0, rand_ready = 0, rand_echo = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // One clock: observe the new cycle's outputs, schedule echoes, drive RX for this cycle.
    task automatic cycle();
        int    idx, t;
        bit    bad_byte;
        echo_t ev;
        @(posedge clk);
        #1;
        cyc++;
        if (tx_valid) begin
            check("tx_ready_prev", 32'(tx_ready), 1);
            check("tx_spacing", 32'(cyc - last_tx_cyc >= 3), 1);
            idx = tx_log.size();
            tx_log.push_back(tx_data);
            last_tx_cyc = cyc;
            inflight++;
            check("tx_window", 32'(inflight <= WIN), 1);
            if (echo_en && idx != drop_idx) begin
                bad_byte = (idx == corrupt_idx) || (rand_echo && $urandom_range(0, 7) == 0);
                if (bad_byte) n_corrupt++;
                t = cyc + (rand_echo ? int'($urandom_range(1, 30)) : 20);
                if (t <= last_echo_t) t = last_echo_t + 1;
                last_echo_t = t;
                echo_q.push_back('{t, bad_byte ? (tx_data ^ 8'hA0) : tx_data});
            end
        end
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
        end
        rx_valid = 1'b0;
        if (echo_q.size() != 0 && echo_q[0].t <= cyc) begin
            ev = echo_q.pop_front();
            rx_valid = 1'b1;
            rx_data = ev.d;
            inflight--;
            last_rx_cyc = cyc;
        end
        if (rand_ready) tx_ready = 1'($urandom_range(0, 1));
    endtask

    task automatic start_burst(input logic [7:0] len);
        tx_log.delete();
        echo_q.delete();
        inflight = 0; done_cnt = 0; n_corrupt = 0;
        last_tx_cyc = -100; last_echo_t = 0; last_rx_cyc = 0;
        burst_len = len;
        start = 1'b1;
        cycle();
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int i;
        i = 0;
        while (done_cnt == 0 && i < budget) begin
            cycle();
            i++;
        end
        check("done_within_budget", 32'(done_cnt != 0), 1);
    endtask

    task automatic check_seq(input string name, input int n);
        int errs;
        errs = 0;
        check({name, "_tx_count"}, tx_log.size(), n);
        for (int i = 0; i < tx_log.size(); i++)
            if (tx_log[i] !== 8'(SEED + i)) errs++;
        check({name, "_tx_order"}, errs, 0);
    endtask

    task automatic check_result(input string name, input int e_sent, input int e_good, input int e_bad, input bit e_pass);
        check({name, "_sent"}, sent, e_sent);
        check({name, "_good"}, good, e_good);
        check({name, "_bad"}, bad, e_bad);
        check({name, "_pass"}, pass, e_pass);
        check({name, "_done_count"}, done_cnt, 1);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int rlen;
        vecs[0] = '{8'd16,  -1, 8'd16,  8'd0, 1'b1};
        vecs[1] = '{8'd16,   5, 8'd15,  8'd1, 1'b0};
        vecs[2] = '{8'd1,   -1, 8'd1,   8'd0, 1'b1};
        vecs[3] = '{8'd5,    4, 8'd4,   8'd1, 1'b0};
        vecs[4] = '{8'd255, -1, 8'd255, 8'd0, 1'b1};

        sysrst = 1'b0; start = 1'b0; abort_i = 1'b0; tx_ready = 1'b0;
        rx_valid = 1'b0; rx_data = 8'd0; burst_len = 8'd0;
        repeat (3) cycle();
        check("reset_flags", {tx_valid, busy, done, pass}, 0);
        check("reset_counters", {sent, good, bad, timeouts}, 0);
        check("reset_tx_data", tx_data, 0);
        sysrst = 1'b1;
        cycle();

        // START latency, first byte, DONE/BUSY alignment
        tx_ready = 1'b1; echo_en = 1;
        start_burst(8'd3);
        check("busy_after_start", busy, 1);
        check("no_tx_at_start_plus1", tx_valid, 0);
        cycle();
        check("first_tx_valid", tx_valid, 1);
        check("first_tx_data", tx_data, SEED);
        wait_done(300);
        check("busy_falls_with_done", busy, 0);
        check("done_after_last_rx", done_cyc - last_rx_cyc, 2);
        repeat (3) cycle();
        check_result("latency", 3, 3, 0, 1);

        for (int v = 0; v < 5; v++) begin
            corrupt_idx = vecs[v].corrupt;
            start_burst(vecs[v].len);
            wait_done(40 * int'(vecs[v].len) + 200);
            repeat (3) cycle();
            check_seq($sformatf("vec%0d", v), vecs[v].len);
            check_result($sformatf("vec%0d", v), vecs[v].len, vecs[v].e_good, vecs[v].e_bad, vecs[v].e_pass);
        end
        corrupt_idx = -1;

        // window fills with no echoes, one echo frees one slot, then abort
        echo_en = 0;
        start_burst(8'd10);
        repeat (60) cycle();
        check_seq("window", 4);
        rx_data = 8'h00; rx_valid = 1'b1; inflight--;
        cycle();
        repeat (30) cycle();
        check_seq("window_refill", 5);
        check("window_good", good, 1);
        abort_i = 1'b1;
        cycle();
        abort_i = 1'b0;
        check("abort_done", done, 1);
        check("abort_pass", pass, 0);
        check("abort_busy", busy, 0);
        check("abort_sent_hold", sent, 5);

        // unsolicited echo while nothing is outstanding
        echo_en = 1; tx_ready = 1'b0;
        start_burst(8'd3);
        rx_data = 8'h55; rx_valid = 1'b1;
        cycle();
        check("unsolicited_bad", bad, 1);
        check("unsolicited_busy", busy, 1);
        tx_ready = 1'b1;
        wait_done(300);
        check_result("unsolicited", 3, 3, 1, 0);

        start_burst(8'd0);
        check("len0_ignored", busy, 0);
        cycle();
        check("len0_no_tx", tx_valid, 0);

`ifdef UART_STRESS_TIMEOUT_EN
        drop_idx = 7;
        start_burst(8'd8);
        wait_done(600);
        check("timeout_latency", done_cyc - last_rx_cyc, 64);
        check("timeout_count", timeouts, 1);
        check("timeout_good", good, 7);
        check("timeout_sent", sent, 8);
        check("timeout_pass", pass, 0);
`else
        drop_idx = 1;
        start_burst(8'd2);
        repeat (300) cycle();
        check("drain_waits_busy", busy, 1);
        check("drain_no_done", done_cnt, 0);
        check("no_timeouts", timeouts, 0);
        abort_i = 1'b1;
        cycle();
        abort_i = 1'b0;
        check("drain_abort_done", done, 1);
`endif
        drop_idx = -1;
        cycle();

        // randomized ready/echo timing against the sequence model
        rand_ready = 1; rand_echo = 1;
        for (int r = 0; r < 6; r++) begin
            rlen = int'($urandom_range(1, 40));
            start_burst(8'(rlen));
            wait_done(3000);
            repeat (2) cycle();
            check_seq($sformatf("rand%0d", r), rlen);
            check_result($sformatf("rand%0d", r), rlen, rlen - n_corrupt, n_corrupt, n_corrupt == 0);
        end
        rand_ready = 0; rand_echo = 0; tx_ready = 1'b1;

        // reset in the middle of a burst
        start_burst(8'd10);
        repeat (12) cycle();
        sysrst = 1'b0;
        cycle();
        check("midrst_flags", {tx_valid, busy, done, pass}, 0);
        check("midrst_counters", {sent, good, bad, timeouts}, 0);
        check("midrst_tx_data", tx_data, 0);
        echo_q.delete();
        rx_valid = 1'b0;
        sysrst = 1'b1;
        done_cnt = 0;
        repeat (40) cycle();
        check("midrst_no_done", done_cnt, 0);
        check("midrst_idle", busy, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
